// File: rtl/adder_tree_accum_if.sv
// Stream bundle for adder_tree_accum: tree-sum input beats and frame-result output.
// slave is the accumulator side, master is the producer/consumer side.
interface adder_tree_accum_if #(
    parameter int IN_WIDTH  = 33,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_sum;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport slave (
        input  in_valid,
        input  in_sum,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_count,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_sum,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_count,
        input  out_ovf
    );
endinterface

// File: rtl/adder_tree_accum.sv
// Frame accumulator behind the registered adder tree: sums the beats of a frame,
// counts them (saturating) and hands the total to the consumer on a valid/ready port.
module adder_tree_accum #(
    parameter int IN_WIDTH  = 33,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    adder_tree_accum_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               state_reg, state_next;
    logic [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 ovf_reg, ovf_next;
    logic                 out_valid_reg, out_valid_next;
    logic [ACC_WIDTH-1:0] out_sum_reg, out_sum_next;
    logic [CNT_WIDTH-1:0] out_count_reg, out_count_next;
    logic                 out_ovf_reg, out_ovf_next;

    logic                 ready;
    logic                 accept;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH:0]   sum_wide;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [ACC_WIDTH-1:0] beat_acc;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic                 beat_ovf;

    // Zero-extend the unsigned tree sum to the accumulator width.
    genvar gi;
    generate
        for (gi = 0; gi < ACC_WIDTH; gi++) begin : g_ext
            if (gi < IN_WIDTH) begin : g_bit
                assign in_ext[gi] = bus.in_sum[gi];
            end else begin : g_zero
                assign in_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign ready        = (state_reg != HOLD);
    assign accept       = bus.in_valid & ready;
    assign bus.in_ready = ready;

    // Value the frame registers take if the current beat is accepted.
    always_comb begin
        sum_wide = {1'b0, acc_reg} + {1'b0, in_ext};
        cnt_inc  = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_WIDTH'(1);
        if (state_reg == IDLE) begin
            beat_acc = in_ext;
            beat_cnt = CNT_WIDTH'(1);
            beat_ovf = 1'b0;
        end else begin
            beat_acc = sum_wide[ACC_WIDTH-1:0];
            beat_cnt = cnt_inc;
            beat_ovf = ovf_reg | sum_wide[ACC_WIDTH] | (cnt_inc == CNT_MAX);
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        ovf_next       = ovf_reg;
        out_valid_next = out_valid_reg;
        out_sum_next   = out_sum_reg;
        out_count_next = out_count_reg;
        out_ovf_next   = out_ovf_reg;
        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_next = beat_acc;
                    cnt_next = beat_cnt;
                    ovf_next = beat_ovf;
                    if (bus.in_last) begin
                        state_next     = HOLD;
                        out_valid_next = 1'b1;
                        out_sum_next   = beat_acc;
                        out_count_next = beat_cnt;
                        out_ovf_next   = beat_ovf;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            HOLD: begin
                // Result fields stay put after the handshake; only valid drops.
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_count_reg <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            ovf_reg       <= ovf_next;
            out_valid_reg <= out_valid_next;
            out_sum_reg   <= out_sum_next;
            out_count_reg <= out_count_next;
            out_ovf_reg   <= out_ovf_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = out_sum_reg;
    assign bus.out_count = out_count_reg;
    assign bus.out_ovf   = out_ovf_reg;
endmodule

// File: tb/tb_adder_tree_accum.sv
// Three accumulators (default, 34-bit accumulator, 2-bit counter) fed the same beats in
// lockstep; a frame-level model pushes expected results and a monitor checks them.
module tb_adder_tree_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_tree_accum_if #(.IN_WIDTH(33), .ACC_WIDTH(48), .CNT_WIDTH(16)) if0 ();
    adder_tree_accum_if #(.IN_WIDTH(34), .ACC_WIDTH(34), .CNT_WIDTH(16)) if1 ();
    adder_tree_accum_if #(.IN_WIDTH(33), .ACC_WIDTH(48), .CNT_WIDTH(2))  if2 ();

    adder_tree_accum #(.IN_WIDTH(33), .ACC_WIDTH(48), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    adder_tree_accum #(.IN_WIDTH(34), .ACC_WIDTH(34), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    adder_tree_accum #(.IN_WIDTH(33), .ACC_WIDTH(48), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct packed {
        logic [2:0][47:0] sum;
        logic [2:0][15:0] cnt;
        logic [2:0]       ovf;
    } exp_t;

    int               n_checks = 0;
    int               n_fail = 0;
    int               n_frames = 0;
    exp_t             sb[$];
    exp_t             last_exp = '0;
    exp_t             mon_e;
    logic             mon_ready;
    logic [2:0][63:0] frame_total = '0;
    int               frame_n = 0;
    int               ready_mode = 1;
    logic             out_ready_r = 1'b0;

    logic [2:0]       o_valid, o_ready, o_ovf;
    logic [2:0][47:0] o_sum;
    logic [2:0][15:0] o_cnt;

    assign if0.out_ready = out_ready_r;
    assign if1.out_ready = out_ready_r;
    assign if2.out_ready = out_ready_r;
    assign o_valid = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign o_ready = {if2.in_ready, if1.in_ready, if0.in_ready};
    assign o_ovf   = {if2.out_ovf, if1.out_ovf, if0.out_ovf};
    assign o_sum[0] = if0.out_sum;
    assign o_sum[1] = {14'd0, if1.out_sum};
    assign o_sum[2] = if2.out_sum;
    assign o_cnt[0] = if0.out_count;
    assign o_cnt[1] = if1.out_count;
    assign o_cnt[2] = {14'd0, if2.out_count};

    function automatic int in_w(int i);
        return (i == 1) ? 34 : 33;
    endfunction
    function automatic int acc_w(int i);
        return (i == 1) ? 34 : 48;
    endfunction
    function automatic int cnt_w(int i);
        return (i == 2) ? 2 : 16;
    endfunction

    function automatic void chk(string name, int i, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, i, act, req, $time);
        end
    endfunction

    // Frame result straight from arithmetic on the whole frame.
    function automatic exp_t make_exp();
        exp_t e;
        longint unsigned cmax, n64;
        int aw;
        e = '0;
        n64 = longint'(frame_n);
        for (int i = 0; i < 3; i++) begin
            aw   = acc_w(i);
            cmax = (64'd1 << cnt_w(i)) - 64'd1;
            e.sum[i] = 48'(frame_total[i] & ((64'd1 << aw) - 64'd1));
            e.cnt[i] = 16'((n64 > cmax) ? cmax : n64);
            e.ovf[i] = ((frame_total[i] >> aw) != 64'd0) || (n64 >= cmax && n64 >= 64'd2);
        end
        return e;
    endfunction

    task automatic drive(input logic valid, input logic [63:0] v, input logic last);
        if0.in_valid = valid; if1.in_valid = valid; if2.in_valid = valid;
        if0.in_sum = v[32:0]; if1.in_sum = v[33:0]; if2.in_sum = v[32:0];
        if0.in_last = last; if1.in_last = last; if2.in_last = last;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat is taken.
    task automatic send(input logic [63:0] v, input logic last);
        int c;
        drive(1'b1, v, last);
        c = 0;
        forever begin
            @(negedge clk);
            if (if0.in_ready) break;
            c++;
            if (c > 400) begin
                chk("in_ready_timeout", 0, 64'd0, 64'd1);
                @(posedge clk); #1;
                drive(1'b0, 64'd0, 1'b0);
                return;
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            frame_total[i] = frame_total[i] + (v & ((64'd1 << in_w(i)) - 64'd1));
        frame_n++;
        if (last) begin
            sb.push_back(make_exp());
            frame_total = '0;
            frame_n = 0;
        end
        #1;
        drive(1'b0, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        frame_total = '0;
        frame_n = 0;
        last_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        if (sb.size() != 0) chk("drain_timeout", 0, 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    always begin
        @(posedge clk); #2;
        case (ready_mode)
            0:       out_ready_r = 1'b0;
            1:       out_ready_r = 1'b1;
            default: out_ready_r = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a pending result must be shown and stable; otherwise the last one lingers.
    always @(negedge clk) begin
        if (!rst) begin
            mon_ready = (sb.size() == 0);
            for (int i = 0; i < 3; i++) chk("in_ready", i, 64'(o_ready[i]), 64'(mon_ready));
            if (sb.size() != 0) begin
                mon_e = sb[0];
                for (int i = 0; i < 3; i++) begin
                    chk("out_valid", i, 64'(o_valid[i]), 64'd1);
                    chk("out_sum", i, 64'(o_sum[i]), 64'(mon_e.sum[i]));
                    chk("out_count", i, 64'(o_cnt[i]), 64'(mon_e.cnt[i]));
                    chk("out_ovf", i, 64'(o_ovf[i]), 64'(mon_e.ovf[i]));
                end
                if (out_ready_r) begin
                    void'(sb.pop_front());
                    last_exp = mon_e;
                    n_frames++;
                    $display("frame %0d: sum 0x%0h/0x%0h/0x%0h count %0d/%0d/%0d ovf %0b/%0b/%0b",
                             n_frames, mon_e.sum[0], mon_e.sum[1], mon_e.sum[2],
                             mon_e.cnt[0], mon_e.cnt[1], mon_e.cnt[2],
                             mon_e.ovf[0], mon_e.ovf[1], mon_e.ovf[2]);
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    chk("idle_valid", i, 64'(o_valid[i]), 64'd0);
                    chk("held_sum", i, 64'(o_sum[i]), 64'(last_exp.sum[i]));
                    chk("held_count", i, 64'(o_cnt[i]), 64'(last_exp.cnt[i]));
                    chk("held_ovf", i, 64'(o_ovf[i]), 64'(last_exp.ovf[i]));
                end
            end
        end
    end

    initial begin
        int len;
        logic [63:0] v;
        drive(1'b0, 64'd0, 1'b0);

        // Reset state
        ready_mode = 1;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 0, 64'(if0.out_valid), 64'd0);
        chk("rst_out_sum", 0, 64'(if0.out_sum), 64'd0);
        chk("rst_out_count", 0, 64'(if0.out_count), 64'd0);
        chk("rst_out_ovf", 0, 64'(if0.out_ovf), 64'd0);
        chk("rst_in_ready", 0, 64'(if0.in_ready), 64'd1);
        @(posedge clk); #1;

        // 5 + 7 + 9 with the consumer always ready
        send(64'd5, 1'b0);
        send(64'd7, 1'b0);
        send(64'd9, 1'b1);
        wait_idle();

        // Single-beat frame held for 4 cycles of back-pressure
        ready_mode = 0;
        send(64'h1_FFFF_FFFF, 1'b1);
        repeat (4) @(negedge clk);
        ready_mode = 1;
        wait_idle();

        // Wrap of the 34-bit accumulator, then a clean frame
        send(64'h3_0000_0000, 1'b0);
        send(64'h1_8000_0000, 1'b1);
        send(64'd1, 1'b0);
        send(64'd1, 1'b1);
        wait_idle();

        // Counter saturation on the 2-bit counter
        for (int b = 0; b < 5; b++) send(64'd1, 1'(b == 4));
        wait_idle();

        // Reset in the middle of a frame discards it
        send(64'd100, 1'b0);
        send(64'd200, 1'b0);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        send(64'd4, 1'b1);
        wait_idle();

        // Random frames with a randomly stalling consumer
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                v = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF;
                if ($urandom_range(0, 7) == 0) v = 64'h3_FFFF_FFFF;
                send(v, 1'(b == len - 1));
                if ($urandom_range(0, 4) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end
        ready_mode = 1;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
